// File: rtl/timer_key_ctrl_if.sv
// Button/timer-control signal bundle between the key front end and its surroundings.
interface timer_key_ctrl_if;
    logic       key_run;
    logic       key_clr;
    logic       start_timer;
    logic       timer_clr_n;
    logic [1:0] state;
    logic       blink;

    // Board side: drives raw keys, observes control and status
    modport master (
        output key_run,
        output key_clr,
        input  start_timer,
        input  timer_clr_n,
        input  state,
        input  blink
    );

    // Controller side
    modport slave (
        input  key_run,
        input  key_clr,
        output start_timer,
        output timer_clr_n,
        output state,
        output blink
    );
endinterface

// File: rtl/timer_key_ctrl.sv
// Stopwatch push-button front end: sync, debounce, long-press detect, IDLE/RUN/PAUSE FSM.
module timer_key_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned LONG_TICKS     = 200,
    parameter int unsigned CLR_TICKS      = 2,
    parameter int unsigned BLINK_HALF     = 50
) (
    input  logic            clk_100Hz,
    input  logic            rst_n,
    timer_key_ctrl_if.slave bus
);
    localparam int unsigned DbW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);
    localparam int unsigned ClrW  = $clog2(CLR_TICKS + 1);
    localparam int unsigned BlW   = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    // Bit 0 is key_run, bit 1 is key_clr
    logic [1:0]     raw;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     deb_q, deb_d, deb_prev_q;
    logic [DbW-1:0] deb_cnt_q [2];
    logic [DbW-1:0] deb_cnt_d [2];

    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_done_q, long_done_d;
    logic             long_hit;
    logic             clr_req_q;

    logic run_press, run_release, clr_press, clr_evt, short_ok;

    state_e          state_q, state_d;
    logic            start_q;
    logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
    logic            clr_n_q;
    logic [BlW-1:0]  blink_cnt_q;
    logic            blink_q;

    assign raw = {bus.key_clr, bus.key_run};

    // Two-flop synchronizer per key
    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: level flips after DEBOUNCE_TICKS consecutive disagreeing samples
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            deb_d[k]     = deb_q[k];
            deb_cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (deb_cnt_q[k] == DbW'(DEBOUNCE_TICKS - 1)) begin
                    deb_d[k] = ~deb_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + DbW'(1);
                end
            end
        end
    end

    assign run_press   = deb_q[0] & ~deb_prev_q[0];
    assign run_release = ~deb_q[0] & deb_prev_q[0];
    assign clr_press   = deb_q[1] & ~deb_prev_q[1];

    // Hold counter saturates, so the long-press hit fires once per press
    always_comb begin
        hold_d      = '0;
        long_hit    = 1'b0;
        long_done_d = long_done_q;
        if (run_press) begin
            long_done_d = 1'b0;
        end
        if (deb_q[0]) begin
            if (hold_q != HoldW'(LONG_TICKS)) begin
                hold_d   = hold_q + HoldW'(1);
                long_hit = (hold_d == HoldW'(LONG_TICKS));
            end else begin
                hold_d = hold_q;
            end
        end
        if (long_hit) begin
            long_done_d = 1'b1;
        end
    end

    assign clr_evt  = clr_press | long_hit;
    // A short press never competes with a pending or active clear
    assign short_ok = run_release & ~long_done_q & clr_n_q & ~clr_evt & ~clr_req_q;

    // Debounced levels, edge history, hold tracking and the registered clear request
    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            deb_q       <= '0;
            deb_prev_q  <= '0;
            deb_cnt_q   <= '{default: '0};
            hold_q      <= '0;
            long_done_q <= 1'b0;
            clr_req_q   <= 1'b0;
        end else begin
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            deb_cnt_q   <= deb_cnt_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            clr_req_q   <= clr_evt;
        end
    end

    // Next state: clear wins, otherwise a short press advances the run/pause cycle
    always_comb begin
        state_d = state_q;
        if (clr_req_q) begin
            state_d = StIdle;
        end else if (short_ok) begin
            case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // Clear pulse length; a new request reloads it
    always_comb begin
        clr_cnt_d = '0;
        if (clr_req_q) begin
            clr_cnt_d = ClrW'(CLR_TICKS);
        end else if (clr_cnt_q != '0) begin
            clr_cnt_d = clr_cnt_q - ClrW'(1);
        end
    end

    // FSM state plus registered outputs: run flag, clear pulse and pause blink
    always_ff @(posedge clk_100Hz) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            clr_cnt_q   <= '0;
            clr_n_q     <= 1'b1;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= (state_d == StRun);
            clr_cnt_q <= clr_cnt_d;
            clr_n_q   <= (clr_cnt_d == '0);
            if (state_q == StPause && state_d == StPause) begin
                if (blink_cnt_q == BlW'(BLINK_HALF - 1)) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BlW'(1);
                end
            end else begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
            end
        end
    end

    assign bus.start_timer = start_q;
    assign bus.timer_clr_n = clr_n_q;
    assign bus.state       = state_q;
    assign bus.blink       = blink_q;
endmodule

// File: tb/tb_timer_key_ctrl.sv
// Directed bench for timer_key_ctrl; outputs packed as {start_timer, timer_clr_n, state, blink}.
module tb_timer_key_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [4:0] O_IDLE     = 5'b0_1_00_0;
    localparam logic [4:0] O_RUN      = 5'b1_1_01_0;
    localparam logic [4:0] O_PAUSE    = 5'b0_1_10_0;
    localparam logic [4:0] O_PAUSE_BL = 5'b0_1_10_1;
    localparam logic [4:0] O_CLR      = 5'b0_0_00_0;

    timer_key_ctrl_if bus ();

    timer_key_ctrl #(
        .DEBOUNCE_TICKS (3),
        .LONG_TICKS     (200),
        .CLR_TICKS      (2),
        .BLINK_HALF     (50)
    ) dut (
        .clk_100Hz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {bus.start_timer, bus.timer_clr_n, bus.state, bus.blink};
    endfunction

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_run = 1'b0;
        bus.key_clr = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            bus.key_run = ~bus.key_run;
            bus.key_clr = (i == 1);
            vectors++;
            if (outs() !== O_IDLE) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, outs(), O_IDLE);
            end
            step(1);
        end
        rst_n = 1'b1;
        bus.key_run = 1'b0;
        bus.key_clr = 1'b0;
        step(10);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", outs(), O_IDLE);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            bus.key_run = ~bus.key_run;
            step(1);
            vectors++;
            if (outs() !== O_IDLE) begin
                miscompares++;
                $display("FAIL bounce_toggle[%0d]: got %b want %b", i, outs(), O_IDLE);
            end
        end
        bus.key_run = 1'b1;
        step(20);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL bounce_held: got %b want %b", outs(), O_IDLE);
        end
        bus.key_run = 1'b0;
        step(5);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL bounce_edge5: got %b want %b", outs(), O_IDLE);
        end
        step(1);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL bounce_edge6: got %b want %b", outs(), O_RUN);
        end
    endtask

    task automatic test_short_cycle();
        bus.key_run = 1'b1;
        step(10);
        bus.key_run = 1'b0;
        step(5);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL pause_edge5: got %b want %b", outs(), O_RUN);
        end
        step(1);
        vectors++;
        if (outs() !== O_PAUSE) begin
            miscompares++;
            $display("FAIL pause_entry: got %b want %b", outs(), O_PAUSE);
        end
        step(49);
        vectors++;
        if (outs() !== O_PAUSE) begin
            miscompares++;
            $display("FAIL blink_49: got %b want %b", outs(), O_PAUSE);
        end
        step(1);
        vectors++;
        if (outs() !== O_PAUSE_BL) begin
            miscompares++;
            $display("FAIL blink_rise50: got %b want %b", outs(), O_PAUSE_BL);
        end
        step(49);
        vectors++;
        if (outs() !== O_PAUSE_BL) begin
            miscompares++;
            $display("FAIL blink_99: got %b want %b", outs(), O_PAUSE_BL);
        end
        step(1);
        vectors++;
        if (outs() !== O_PAUSE) begin
            miscompares++;
            $display("FAIL blink_fall100: got %b want %b", outs(), O_PAUSE);
        end
        step(50);
        vectors++;
        if (outs() !== O_PAUSE_BL) begin
            miscompares++;
            $display("FAIL blink_rise150: got %b want %b", outs(), O_PAUSE_BL);
        end
        bus.key_run = 1'b1;
        step(10);
        bus.key_run = 1'b0;
        step(5);
        vectors++;
        if (outs() !== O_PAUSE_BL) begin
            miscompares++;
            $display("FAIL resume_edge5: got %b want %b", outs(), O_PAUSE_BL);
        end
        step(1);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL resume_edge6: got %b want %b", outs(), O_RUN);
        end
        step(60);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL run_no_blink: got %b want %b", outs(), O_RUN);
        end
    endtask

    task automatic test_long_press();
        bus.key_run = 1'b1;
        step(205);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL long_edge205: got %b want %b", outs(), O_RUN);
        end
        step(1);
        vectors++;
        if (outs() !== O_CLR) begin
            miscompares++;
            $display("FAIL long_clr1: got %b want %b", outs(), O_CLR);
        end
        step(1);
        vectors++;
        if (outs() !== O_CLR) begin
            miscompares++;
            $display("FAIL long_clr2: got %b want %b", outs(), O_CLR);
        end
        step(1);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL long_clr_end: got %b want %b", outs(), O_IDLE);
        end
        step(42);
        bus.key_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            vectors++;
            if (outs() !== O_IDLE) begin
                miscompares++;
                $display("FAIL long_release[%0d]: got %b want %b", i, outs(), O_IDLE);
            end
        end
        bus.key_run = 1'b1;
        step(10);
        bus.key_run = 1'b0;
        step(6);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL long_then_short: got %b want %b", outs(), O_RUN);
        end
    endtask

    task automatic test_simultaneous();
        bus.key_run = 1'b1;
        step(10);
        bus.key_run = 1'b0;
        step(6);
        vectors++;
        if (outs() !== O_PAUSE) begin
            miscompares++;
            $display("FAIL sim_enter_pause: got %b want %b", outs(), O_PAUSE);
        end
        step(4);
        bus.key_run = 1'b1;
        step(10);
        bus.key_run = 1'b0;
        bus.key_clr = 1'b1;
        step(6);
        vectors++;
        if (outs() !== O_PAUSE) begin
            miscompares++;
            $display("FAIL sim_no_resume: got %b want %b", outs(), O_PAUSE);
        end
        step(1);
        vectors++;
        if (outs() !== O_CLR) begin
            miscompares++;
            $display("FAIL sim_clr1: got %b want %b", outs(), O_CLR);
        end
        step(1);
        vectors++;
        if (outs() !== O_CLR) begin
            miscompares++;
            $display("FAIL sim_clr2: got %b want %b", outs(), O_CLR);
        end
        step(1);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL sim_clr_end: got %b want %b", outs(), O_IDLE);
        end
        bus.key_clr = 1'b0;
        step(10);
        // Short press whose release event lands inside the clear pulse
        bus.key_run = 1'b1;
        step(20);
        bus.key_clr = 1'b1;
        step(2);
        bus.key_run = 1'b0;
        step(5);
        vectors++;
        if (outs() !== O_CLR) begin
            miscompares++;
            $display("FAIL discard_clr1: got %b want %b", outs(), O_CLR);
        end
        step(1);
        vectors++;
        if (outs() !== O_CLR) begin
            miscompares++;
            $display("FAIL discard_clr2: got %b want %b", outs(), O_CLR);
        end
        step(1);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL discard_end: got %b want %b", outs(), O_IDLE);
        end
        step(5);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL discard_stays_idle: got %b want %b", outs(), O_IDLE);
        end
        bus.key_clr = 1'b0;
        step(10);
    endtask

    task automatic test_reset_mid_clear();
        bus.key_run = 1'b1;
        step(10);
        bus.key_run = 1'b0;
        step(6);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL rmc_run: got %b want %b", outs(), O_RUN);
        end
        bus.key_clr = 1'b1;
        step(6);
        vectors++;
        if (outs() !== O_RUN) begin
            miscompares++;
            $display("FAIL rmc_edge6: got %b want %b", outs(), O_RUN);
        end
        step(1);
        vectors++;
        if (outs() !== O_CLR) begin
            miscompares++;
            $display("FAIL rmc_edge7: got %b want %b", outs(), O_CLR);
        end
        rst_n = 1'b0;
        step(1);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL rmc_reset: got %b want %b", outs(), O_IDLE);
        end
        rst_n = 1'b1;
        bus.key_clr = 1'b0;
        step(1);
        vectors++;
        if (outs() !== O_IDLE) begin
            miscompares++;
            $display("FAIL rmc_after_reset: got %b want %b", outs(), O_IDLE);
        end
        bus.key_clr = 1'b1;
        step(2);
        bus.key_clr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            vectors++;
            if (outs() !== O_IDLE) begin
                miscompares++;
                $display("FAIL glitch[%0d]: got %b want %b", i, outs(), O_IDLE);
            end
        end
    endtask

    initial begin
        bus.key_run = 1'b0;
        bus.key_clr = 1'b0;
        test_reset();
        test_bounce();
        test_short_cycle();
        test_long_press();
        test_simultaneous();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
